masked_chi3_sink: RTL and testbench
===================================

MASKED_CHI3_SINK -- requirements
Module: masked_chi3_sink

Purpose: downstream consumer of the 2-share, 3-bit masked chi pipeline (5-cycle latency, one input per cycle, no stall). The block tracks in-flight launches, remasks each result with fresh randomness, buffers it, and presents it on a valid/ready port. Launch credit is issued upstream so that results are never lost.

Interface
REQ-001 Parameter LATENCY, default 5: number of clock edges from a chi launch to a valid chi result.
REQ-002 Parameter DEPTH, default 8: number of FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port launch_valid, input, 1: upstream is applying a new share pair to the chi pipeline this cycle.
REQ-006 Port launch_ready, output, 1: a launch this cycle is accepted and credited.
REQ-007 Port chi_share0, input, 3: share 0 output of the chi pipeline.
REQ-008 Port chi_share1, input, 3: share 1 output of the chi pipeline.
REQ-009 Port rand_in, input, 3: fresh remask bits, consumed only on a capture cycle.
REQ-010 Port out_valid, output, 1: head FIFO entry is available.
REQ-011 Port out_ready, input, 1: downstream accepts the head entry.
REQ-012 Port out_share0, output, 3: remasked share 0 of the head entry.
REQ-013 Port out_share1, output, 3: remasked share 1 of the head entry.
REQ-014 Port fifo_count, output, clog2(DEPTH)+1: number of occupied FIFO entries.

Function
REQ-015 A launch SHALL occur when launch_valid=1 and launch_ready=1 in the same cycle; the bench/upstream SHALL NOT drive chi inputs otherwise.
REQ-016 A LATENCY-bit token shift register SHALL shift every cycle; bit 0 SHALL load the launch strobe.
REQ-017 A capture SHALL occur in the cycle where token bit LATENCY-1 is 1; for a launch in cycle t, this is cycle t+LATENCY.
REQ-018 On capture, the FIFO SHALL write {chi_share0^rand_in, chi_share1^rand_in} at the tail.
REQ-019 Each share SHALL be remasked and stored in separate registers; no gate SHALL combine chi_share0 and chi_share1.
REQ-020 The number of in-flight launches SHALL equal the popcount of the token register, or an equivalent up/down counter.
REQ-021 launch_ready SHALL be 1 iff fifo_count + in-flight < DEPTH, using registered values only.
REQ-022 A pop in the current cycle SHALL NOT free credit until the next cycle.
REQ-023 out_valid SHALL be 1 iff fifo_count != 0.
REQ-024 Both output shares SHALL be driven from the head entry registers.
REQ-025 When out_valid=0, out_share0 and out_share1 SHALL be 3'b000, so stale shares never appear on the outputs.
REQ-026 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-027 Push with no pop SHALL increment fifo_count; pop with no push SHALL decrement it; push and pop together SHALL leave it unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Latency through an empty FIFO SHALL be 1 cycle (capture in cycle c gives out_valid in cycle c+1); there SHALL be no combinational bypass.
REQ-030 The FIFO SHALL preserve order: results leave in launch order.
REQ-031 A capture while fifo_count=DEPTH with no pop is unreachable by REQ-021; an assertion SHALL flag it.

Reset
REQ-032 While rst_n=0 at an edge, the block SHALL clear the token register, pointers and fifo_count.
REQ-033 During reset, launch_valid SHALL be ignored.
REQ-034 In the cycle after reset, out_valid=0, out_share0=out_share1=0, fifo_count=0 and launch_ready=1.
REQ-035 FIFO storage need not be reset.
REQ-036 Reset mid-operation SHALL discard all in-flight and stored results; chi outputs still emerging from the pipeline SHALL NOT be captured.

Verification
REQ-037 The bench drives chi_share0/1 directly. Reset held 2 cycles -> out_valid=0, outputs 0, fifo_count=0, launch_ready=1 on release.
REQ-038 Single launch at cycle 0. At cycle 5 drive chi_share0=101, chi_share1=011, rand_in=110 -> cycle 6: out_valid=1, out_share0=011, out_share1=101, and the XOR of the two outputs is 110.
REQ-039 out_ready=0 with launch_valid held high -> exactly 8 launches accepted, then launch_ready=0 and fifo_count reaches 8. Then out_ready=1 -> 8 entries drain in order and launch_ready reasserts one cycle after the first pop.
REQ-040 fifo_count=3 with a capture and a pop in the same cycle -> fifo_count stays 3 and head advances.
REQ-041 Reset asserted with 3 launches in flight and 2 stored -> after release fifo_count=0, and out_valid stays 0 for 10 cycles while chi inputs toggle.
REQ-042 1000 random launches with random out_ready and rand_in -> order preserved, each out_share0^out_share1 equals chi_share0^chi_share1 at capture, and the overflow assertion never fires.

Source files
------------

// File: rtl/masked_chi3_sink.sv
// Sink for the 2-share masked chi pipeline. It tracks in-flight launches, remasks
// each result, queues it in a FIFO, and only grants launches that have a FIFO slot.
module masked_chi3_sink #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    launch_valid,
    output logic                    launch_ready,
    input  logic [2:0]              chi_share0,
    input  logic [2:0]              chi_share1,
    input  logic [2:0]              rand_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_share0,
    output logic [2:0]              out_share1,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [LATENCY-1:0] vld_pipe;
    logic [CW-1:0]      in_flight;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [2:0]         mem0 [DEPTH];
    logic [2:0]         mem1 [DEPTH];
    logic               launch;
    logic               capture;
    logic               pop;
    logic [CW:0]        credit_used;

    assign launch  = launch_valid && launch_ready;
    assign capture = vld_pipe[LATENCY-1];
    assign pop     = out_valid && out_ready;

    // Credit is computed from registered state only, so a pop frees a slot one cycle later.
    assign credit_used  = {1'b0, fifo_count} + {1'b0, in_flight};
    assign launch_ready = credit_used < DEPTH_W;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            in_flight <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_count <= '0;
        end else begin
            vld_pipe <= LATENCY'({vld_pipe, launch});
            case ({launch, capture})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
            if (capture) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Each share is remasked and stored on its own; the two shares never meet in logic.
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            mem0[wr_ptr] <= chi_share0 ^ rand_in;
            mem1[wr_ptr] <= chi_share1 ^ rand_in;
        end
    end

    assign out_valid  = fifo_count != '0;
    assign out_share0 = out_valid ? mem0[rd_ptr] : 3'b000;
    assign out_share1 = out_valid ? mem1[rd_ptr] : 3'b000;

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !pop && fifo_count == FULL));

endmodule

// File: tb/tb_masked_chi3_sink.sv
// Directed and randomized checks of the masked chi sink against a launch/result scoreboard.
module tb_masked_chi3_sink;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       launch_valid = 1'b0;
    logic       launch_ready;
    logic [2:0] chi_share0 = '0;
    logic [2:0] chi_share1 = '0;
    logic [2:0] rand_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_share0;
    logic [2:0] out_share1;
    logic [3:0] fifo_count;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_launch = 0;
    int lq[$];
    logic [5:0] exp_q[$];

    masked_chi3_sink #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .chi_share0(chi_share0), .chi_share1(chi_share1), .rand_in(rand_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_share0(out_share0), .out_share1(out_share1),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One cycle: check registered state against the scoreboard, then drive and record handshakes.
    task automatic run_cycle(input logic lv, input logic ordy);
        logic       cap;
        logic [2:0] c0, c1, r;
        logic [5:0] e;
        check("count", fifo_count, exp_q.size());
        check("valid", out_valid, exp_q.size() != 0);
        check("credit", launch_ready, (exp_q.size() + lq.size()) < DEPTH);
        if (!out_valid) check("idle_shares", {out_share0, out_share1}, 0);
        cap = (lq.size() != 0) && (lq[0] == cyc - LAT);
        r = 3'($urandom);
        c0 = '0;
        c1 = '0;
        if (cap) begin
            c0 = 3'($urandom);
            c1 = 3'($urandom);
            void'(lq.pop_front());
        end
        launch_valid = lv;
        out_ready    = ordy;
        chi_share0   = c0;
        chi_share1   = c1;
        rand_in      = r;
        if (out_valid && ordy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("head", {out_share0, out_share1}, e);
            check("unmasked", out_share0 ^ out_share1, e[5:3] ^ e[2:0]);
        end
        if (cap) exp_q.push_back({c0 ^ r, c1 ^ r});
        if (lv && launch_ready) begin
            lq.push_back(cyc);
            n_launch++;
        end
        tick();
    endtask

    initial begin
        int start;
        int guard;
        logic [5:0] head2;

        // Reset for two edges with launch_valid high; launches must be ignored.
        launch_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        launch_valid = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_shares", {out_share0, out_share1}, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", launch_ready, 1);

        // Single launch at cycle 0, result driven at cycle 5, visible at cycle 6.
        launch_valid = 1'b1;
        tick();
        launch_valid = 1'b0;
        repeat (4) tick();
        check("pre_capture_valid", out_valid, 0);
        chi_share0 = 3'b101;
        chi_share1 = 3'b011;
        rand_in    = 3'b110;
        tick();
        chi_share0 = '0;
        chi_share1 = '0;
        rand_in    = '0;
        check("single_valid", out_valid, 1);
        check("single_sh0", out_share0, 3'b011);
        check("single_sh1", out_share1, 3'b101);
        check("single_xor", out_share0 ^ out_share1, 3'b110);
        check("single_count", fifo_count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_popped", out_valid, 0);
        check("single_idle_sh", {out_share0, out_share1}, 0);

        // Fill with out_ready low: exactly DEPTH launches are granted.
        start = n_launch;
        repeat (20) run_cycle(1'b1, 1'b0);
        check("fill_launches", n_launch - start, DEPTH);
        check("fill_ready", launch_ready, 0);
        check("fill_count", fifo_count, DEPTH);
        run_cycle(1'b0, 1'b1);
        check("ready_reassert", launch_ready, 1);
        repeat (7) run_cycle(1'b0, 1'b1);
        check("drain_count", fifo_count, 0);

        // Capture and pop in the same cycle at fifo_count=3.
        repeat (4) run_cycle(1'b1, 1'b0);
        repeat (4) run_cycle(1'b0, 1'b0);
        check("c3_count", fifo_count, 3);
        head2 = exp_q[1];
        run_cycle(1'b0, 1'b1);
        check("c3_count_hold", fifo_count, 3);
        check("c3_head_adv", {out_share0, out_share1}, head2);
        repeat (6) run_cycle(1'b0, 1'b1);
        check("c3_drained", fifo_count, 0);

        // Reset with 3 launches in flight and 2 results stored.
        repeat (5) run_cycle(1'b1, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0);
        check("pre_rst_count", fifo_count, 2);
        check("pre_rst_inflight", lq.size(), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lq.delete();
        exp_q.delete();
        check("mid_rst_count", fifo_count, 0);
        for (int i = 0; i < 10; i++) begin
            chi_share0 = 3'($urandom);
            chi_share1 = 3'($urandom);
            rand_in    = 3'($urandom);
            tick();
            check("post_rst_valid", out_valid, 0);
            check("post_rst_shares", {out_share0, out_share1}, 0);
        end
        chi_share0 = '0;
        chi_share1 = '0;

        // Random traffic: 1000 launches with random out_ready and remask bits.
        start = n_launch;
        guard = 0;
        while ((n_launch - start) < 1000 && guard < 20000) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            guard++;
        end
        check("rand_launches", n_launch - start, 1000);
        guard = 0;
        while ((lq.size() != 0 || exp_q.size() != 0) && guard < 200) begin
            run_cycle(1'b0, 1'b1);
            guard++;
        end
        check("rand_drained_q", exp_q.size() + lq.size(), 0);
        check("rand_drained_count", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
